// File: rtl/pic_pkg.sv
// Shared definitions for the 8259-style interrupt controller slice.
package pic_pkg;

    localparam int NUM_IR = 8;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK1,
        ST_ACK2
    } pic_state_t;

    function automatic logic [NUM_IR-1:0] levelToMask(input logic [2:0] level);
        return {{(NUM_IR-1){1'b0}}, 1'b1} << level;
    endfunction

endpackage

// File: rtl/priority_resolver.sv
// Fixed-priority resolver: lowest unmasked IRR index wins, but only if it
// outranks everything already in service (fully nested mode).
module priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] irr,
    input  logic [NUM_IR-1:0] imr,
    input  logic [NUM_IR-1:0] isr,
    output logic              valid,
    output logic [2:0]        level
);

    logic [NUM_IR-1:0] w_req;
    logic              w_winValid;
    logic [2:0]        w_winLevel;
    logic              w_isrValid;
    logic [2:0]        w_isrLevel;

    always_comb begin
        w_req      = irr & ~imr;
        w_winValid = 1'b0;
        w_winLevel = 3'd0;
        w_isrValid = 1'b0;
        w_isrLevel = 3'd0;
        // Scan downward so the last hit is the lowest index.
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_winValid = 1'b1;
                w_winLevel = 3'(i);
            end
            if (isr[i]) begin
                w_isrValid = 1'b1;
                w_isrLevel = 3'(i);
            end
        end
        valid = w_winValid && (!w_isrValid || (w_winLevel < w_isrLevel));
        level = w_winLevel;
    end

endmodule

// File: rtl/interrupt_sequence_controller.sv
// Request latching, INT generation and the two-pulse INTA handshake that
// moves the winning request into service and presents its vector.
module interrupt_sequence_controller #(
    parameter bit AUTO_EOI = 1'b0,
    parameter int NUM_IR   = 8
) (
    input  logic              clk,
    input  logic              rst_neg,
    input  logic [NUM_IR-1:0] ir,
    input  logic              ltim,
    input  logic [NUM_IR-1:0] imr,
    input  logic [4:0]        vector_base,
    input  logic              inta_neg,
    input  logic              eoi_nonspecific,
    input  logic              eoi_specific,
    input  logic [2:0]        eoi_level,
    output logic              int_out,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] isr,
    output logic [7:0]        vector_out,
    output logic              vector_oe
);

    import pic_pkg::*;

    pic_state_t        r_state;
    logic [2:0]        r_lvl;
    logic              r_spurious;
    logic              r_intOut;
    logic [7:0]        r_vectorOut;
    logic              r_vectorOe;
    logic [NUM_IR-1:0] r_irPrev;
    logic [NUM_IR-1:0] r_irr;
    logic [NUM_IR-1:0] r_isr;
    logic              r_intaPrev;

    logic              w_valid;
    logic [2:0]        w_level;
    logic              w_intaFall;
    logic              w_intaRise;
    logic [NUM_IR-1:0] w_ack1Set;
    logic [NUM_IR-1:0] w_eoiClr;
    logic [NUM_IR-1:0] w_autoClr;
    logic [NUM_IR-1:0] w_irrNext;
    logic [NUM_IR-1:0] w_isrNext;

    priority_resolver u_resolver (
        .irr   (r_irr),
        .imr   (imr),
        .isr   (r_isr),
        .valid (w_valid),
        .level (w_level)
    );

    assign w_intaFall = !inta_neg && r_intaPrev;
    assign w_intaRise = inta_neg && !r_intaPrev;
    assign w_ack1Set  = ((r_state == ST_REQ) && w_intaFall && w_valid) ? levelToMask(w_level) : '0;
    assign w_autoClr  = (AUTO_EOI && (r_state == ST_ACK2) && w_intaRise && !r_spurious)
                        ? levelToMask(r_lvl) : '0;

    // Specific EOI overrides a simultaneous non-specific one.
    always_comb begin
        w_eoiClr = '0;
        if (eoi_specific) begin
            w_eoiClr = levelToMask(eoi_level);
        end else if (eoi_nonspecific) begin
            w_eoiClr = r_isr & (~r_isr + 1'b1);
        end
    end

    // ACK1 clear beats a same-cycle new edge; ACK1 set beats a same-cycle EOI.
    assign w_irrNext = (ltim ? ir : (r_irr | (ir & ~r_irPrev))) & ~w_ack1Set;
    assign w_isrNext = (r_isr & ~w_eoiClr & ~w_autoClr) | w_ack1Set;

    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            r_irPrev   <= '0;
            r_intaPrev <= 1'b1;
            r_irr      <= '0;
            r_isr      <= '0;
        end else begin
            r_irPrev   <= ir;
            r_intaPrev <= inta_neg;
            r_irr      <= w_irrNext;
            r_isr      <= w_isrNext;
        end
    end

    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            r_state     <= ST_IDLE;
            r_lvl       <= 3'd0;
            r_spurious  <= 1'b0;
            r_intOut    <= 1'b0;
            r_vectorOut <= 8'd0;
            r_vectorOe  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state  <= ST_REQ;
                        r_intOut <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // A request withdrawn before INTA is served as the spurious level.
                    if (w_intaFall) begin
                        r_state    <= ST_ACK1;
                        r_intOut   <= 1'b0;
                        r_lvl      <= w_valid ? w_level : SPURIOUS_LEVEL;
                        r_spurious <= !w_valid;
                    end
                end
                ST_ACK1: begin
                    if (w_intaFall) begin
                        r_state     <= ST_ACK2;
                        r_vectorOut <= {vector_base, r_lvl};
                        r_vectorOe  <= 1'b1;
                    end
                end
                ST_ACK2: begin
                    if (w_intaRise) begin
                        r_state    <= ST_IDLE;
                        r_vectorOe <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign int_out    = r_intOut;
    assign irr        = r_irr;
    assign isr        = r_isr;
    assign vector_out = r_vectorOut;
    assign vector_oe  = r_vectorOe;

endmodule

// File: tb/tb_interrupt_sequence_controller.sv
// Directed bench for the interrupt sequencer; one instance per AUTO_EOI setting.
module tb_interrupt_sequence_controller;

    logic       clk = 1'b0;
    logic       rst_neg = 1'b0;
    logic [7:0] ir = 8'd0;
    logic       ltim = 1'b0;
    logic [7:0] imr = 8'd0;
    logic [4:0] vector_base = 5'h08;
    logic       inta_neg = 1'b1;
    logic       eoi_nonspecific = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;

    logic       intA, intB;
    logic [7:0] irrA, irrB, isrA, isrB, vecA, vecB;
    logic       oeA, oeB;

    typedef struct {
        string      tag;
        logic [7:0] value;
    } exp_t;

    exp_t sbQueue[$];
    int   assertCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    interrupt_sequence_controller #(.AUTO_EOI(1'b0), .NUM_IR(8)) dutA (
        .clk(clk), .rst_neg(rst_neg), .ir(ir), .ltim(ltim), .imr(imr),
        .vector_base(vector_base), .inta_neg(inta_neg),
        .eoi_nonspecific(eoi_nonspecific), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .int_out(intA), .irr(irrA), .isr(isrA), .vector_out(vecA), .vector_oe(oeA)
    );

    interrupt_sequence_controller #(.AUTO_EOI(1'b1), .NUM_IR(8)) dutB (
        .clk(clk), .rst_neg(rst_neg), .ir(ir), .ltim(ltim), .imr(imr),
        .vector_base(vector_base), .inta_neg(inta_neg),
        .eoi_nonspecific(eoi_nonspecific), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .int_out(intB), .irr(irrB), .isr(isrB), .vector_out(vecB), .vector_oe(oeB)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expectVal(input string tag, input logic [7:0] value);
        exp_t e;
        e.tag = tag;
        e.value = value;
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput(input logic [7:0] observed);
        exp_t e;
        assertCount++;
        if (sbQueue.size() == 0) begin
            failCount++;
            $error("[TB] FAIL scoreboard_empty: observed %02h required none", observed);
        end else begin
            e = sbQueue.pop_front();
            assert (observed === e.value) else begin
                failCount++;
                $error("[TB] FAIL %s: observed %02h required %02h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] expected, input logic [7:0] observed);
        expectVal(tag, expected);
        checkOutput(observed);
    endtask

    // One-cycle edge-mode request pulse; returns once IRR has latched it.
    task automatic applyStimulus(input logic [7:0] irPulse);
        ir = irPulse;
        step(1);
        ir = 8'd0;
    endtask

    task automatic intaFirst();
        inta_neg = 1'b0;
        step(1);
        inta_neg = 1'b1;
        step(1);
    endtask

    task automatic intaSecond(input string tag, input logic [7:0] expVec);
        inta_neg = 1'b0;
        step(1);
        check({tag, "_vec"}, expVec, vecA);
        check({tag, "_oe_on"}, 8'd1, {7'd0, oeA});
        inta_neg = 1'b1;
        step(1);
        check({tag, "_oe_off"}, 8'd0, {7'd0, oeA});
    endtask

    task automatic eoiNonSpecific();
        eoi_nonspecific = 1'b1;
        step(1);
        eoi_nonspecific = 1'b0;
    endtask

    task automatic eoiSpecific(input logic [2:0] level);
        eoi_specific = 1'b1;
        eoi_level = level;
        step(1);
        eoi_specific = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        step(2);
        check("rst_int", 8'd0, {7'd0, intA});
        check("rst_irr", 8'h00, irrA);
        check("rst_isr", 8'h00, isrA);
        check("rst_vec", 8'h00, vecA);
        check("rst_oe", 8'd0, {7'd0, oeA});
        rst_neg = 1'b1;
        step(1);

        // Basic edge-mode request on IR3
        applyStimulus(8'h08);
        check("t1_int_early", 8'd0, {7'd0, intA});
        check("t1_irr", 8'h08, irrA);
        step(1);
        check("t1_int", 8'd1, {7'd0, intA});
        intaFirst();
        check("t1_isr", 8'h08, isrA);
        check("t1_irr_clr", 8'h00, irrA);
        check("t1_int_drop", 8'd0, {7'd0, intA});
        intaSecond("t1", 8'h43);
        check("t1_isr_hold", 8'h08, isrA);
        eoiNonSpecific();
        check("t1_eoi", 8'h00, isrA);

        // Simultaneous IR5 and IR2
        applyStimulus(8'h24);
        step(1);
        check("t2_int", 8'd1, {7'd0, intA});
        intaFirst();
        check("t2_isr", 8'h04, isrA);
        check("t2_irr", 8'h20, irrA);
        intaSecond("t2", 8'h42);
        step(2);
        check("t2_blocked", 8'd0, {7'd0, intA});
        eoiNonSpecific();
        check("t2_isr_eoi", 8'h00, isrA);
        check("t2_int_pre", 8'd0, {7'd0, intA});
        step(1);
        check("t2_int_ir5", 8'd1, {7'd0, intA});
        intaFirst();
        check("t2_isr5", 8'h20, isrA);
        intaSecond("t2b", 8'h45);
        eoiSpecific(3'd5);
        check("t2_eoi_sp", 8'h00, isrA);

        // Nesting IR4 then IR1, IR6 held off
        applyStimulus(8'h10);
        step(1);
        intaFirst();
        intaSecond("t3a", 8'h44);
        applyStimulus(8'h02);
        step(1);
        check("t3_int_nest", 8'd1, {7'd0, intA});
        intaFirst();
        check("t3_isr_nest", 8'h12, isrA);
        intaSecond("t3b", 8'h41);
        applyStimulus(8'h40);
        step(2);
        check("t3_irr6", 8'h40, irrA);
        check("t3_int6_blocked", 8'd0, {7'd0, intA});
        eoi_nonspecific = 1'b1;
        eoiSpecific(3'd4);
        eoi_nonspecific = 1'b0;
        check("t3_both_eoi", 8'h02, isrA);
        step(1);
        check("t3_int6_still", 8'd0, {7'd0, intA});
        eoiNonSpecific();
        check("t3_isr_empty", 8'h00, isrA);
        step(1);
        check("t3_int6", 8'd1, {7'd0, intA});
        intaFirst();
        intaSecond("t3c", 8'h46);
        check("t3_isr6", 8'h40, isrA);
        eoiSpecific(3'd6);
        check("t3_eoi6", 8'h00, isrA);
        eoiNonSpecific();
        check("t3_eoi_empty", 8'h00, isrA);

        // Masking IR0
        imr = 8'h01;
        applyStimulus(8'h01);
        step(2);
        check("t4_irr", 8'h01, irrA);
        check("t4_masked", 8'd0, {7'd0, intA});
        imr = 8'h00;
        step(1);
        check("t4_unmask", 8'd1, {7'd0, intA});
        intaFirst();
        intaSecond("t4", 8'h40);
        check("t4_isr", 8'h01, isrA);
        eoiNonSpecific();

        // Level-mode spurious request
        ltim = 1'b1;
        check("t5_irr_pre", 8'h00, irrA);
        ir = 8'h04;
        step(2);
        check("t5_int", 8'd1, {7'd0, intA});
        ir = 8'h00;
        step(1);
        check("t5_irr_drop", 8'h00, irrA);
        check("t5_int_hold", 8'd1, {7'd0, intA});
        intaFirst();
        check("t5_isr", 8'h00, isrA);
        intaSecond("t5", 8'h47);
        check("t5_isr_after", 8'h00, isrA);
        ltim = 1'b0;

        // Auto-EOI versus normal EOI, then reset mid-handshake
        rst_neg = 1'b0;
        step(1);
        rst_neg = 1'b1;
        step(1);
        applyStimulus(8'h01);
        step(1);
        check("t6_intA", 8'd1, {7'd0, intA});
        check("t6_intB", 8'd1, {7'd0, intB});
        intaFirst();
        check("t6_isrB_set", 8'h01, isrB);
        inta_neg = 1'b0;
        step(1);
        check("t6_vecB", 8'h40, vecB);
        check("t6_isrB_hold", 8'h01, isrB);
        inta_neg = 1'b1;
        step(1);
        check("t6_isrB_auto", 8'h00, isrB);
        check("t6_isrA_kept", 8'h01, isrA);
        applyStimulus(8'h02);
        step(1);
        check("t6_intA_blocked", 8'd0, {7'd0, intA});
        check("t6_intB_ir1", 8'd1, {7'd0, intB});
        intaFirst();
        check("t6_isrB_ack1", 8'h02, isrB);
        #2;
        rst_neg = 1'b0;
        #1;
        check("t6_rst_isrB", 8'h00, isrB);
        check("t6_rst_irrB", 8'h00, irrB);
        check("t6_rst_intB", 8'd0, {7'd0, intB});
        check("t6_rst_vecB", 8'h00, vecB);
        check("t6_rst_oeB", 8'd0, {7'd0, oeB});
        check("t6_rst_isrA", 8'h00, isrA);
        step(1);
        rst_neg = 1'b1;
        step(3);
        check("t6_post_isrB", 8'h00, isrB);
        check("t6_post_intB", 8'd0, {7'd0, intB});

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
